// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative unsigned shift-add multiplier / restoring divider
module muldiv_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic op_r, accept, dz, last;
  logic [WIDTH-1:0] m, acc, lo, acc_nx, lo_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] alu_a, alu_b, alu;
  assign accept = state == IDLE && start;
  assign dz     = op && b == '0;
  assign last   = cnt == CW'(WIDTH - 1);
  always_comb begin
    alu_a  = op_r ? {acc, lo[WIDTH-1]} : {1'b0, acc};
    alu_b  = {1'b0, (op_r || lo[0]) ? m : {WIDTH{1'b0}}};
    alu    = alu_a + (op_r ? ~alu_b : alu_b) + {{WIDTH{1'b0}}, op_r};
    acc_nx = op_r ? (alu[WIDTH] ? alu_a[WIDTH-1:0] : alu[WIDTH-1:0]) : alu[WIDTH:1];
    lo_nx  = op_r ? {lo[WIDTH-2:0], ~alu[WIDTH]} : {alu[0], lo[WIDTH-1:1]};
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? (dz ? DONE : RUN) : IDLE;
      RUN:     state_nx = last ? DONE : RUN;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r        <= 1'b0;
      m           <= '0;
      acc         <= '0;
      lo          <= '0;
      cnt         <= '0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      op_r        <= op;
      m           <= b;
      acc         <= '0;
      lo          <= a;
      cnt         <= '0;
      div_by_zero <= dz;
      if (dz) begin
        result_lo <= '1;
        result_hi <= a;
      end
    end else if (state == RUN) begin
      acc <= acc_nx;
      lo  <= lo_nx;
      cnt <= cnt + CW'(1);
      if (last) begin
        result_lo <= lo_nx;
        result_hi <= acc_nx;
      end
    end
  end
endmodule
